// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard unit for the 5-stage RV32 core (F/D/E/M/W).
// Provides M/W -> E operand forwarding, load-use stall, taken-branch flush and a
// one-entry scoreboard that tracks the multi-cycle divider.
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   D_Rs1/D_Rs2/D_Rd          Decode source/destination registers
//   D_RegWrite, D_IsDiv       Decode writes D_Rd / Decode instruction is a divide
//   E_Rs1/E_Rs2/E_Rd          Execute source/destination registers
//   E_MemRead                 Execute instruction is a load
//   E_DivStart                divider issuing from Execute this cycle
//   E_PCSrc                   taken branch/jump resolved in Execute
//   M_Rd/M_RegWrite           Memory-stage destination and write enable
//   W_Rd/W_RegWrite           Writeback-stage destination and write enable
//   ForwardAE/ForwardBE       operand selects: 00 RF, 01 W result, 10 M result
//   StallF/StallD             hold PC / hold F->D register
//   FlushD/FlushE             bubble F->D / D->E register
//   DivBusy/DivRd/DivDone     divide in flight / its destination / completion pulse
module hazard_scoreboard_unit #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned DIV_LATENCY = 33,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] D_Rs1,
  input  logic [REG_AW-1:0] D_Rs2,
  input  logic [REG_AW-1:0] D_Rd,
  input  logic              D_RegWrite,
  input  logic              D_IsDiv,
  input  logic [REG_AW-1:0] E_Rs1,
  input  logic [REG_AW-1:0] E_Rs2,
  input  logic [REG_AW-1:0] E_Rd,
  input  logic              E_MemRead,
  input  logic              E_DivStart,
  input  logic              E_PCSrc,
  input  logic [REG_AW-1:0] M_Rd,
  input  logic [REG_AW-1:0] W_Rd,
  input  logic              M_RegWrite,
  input  logic              W_RegWrite,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic              DivBusy,
  output logic [REG_AW-1:0] DivRd,
  output logic              DivDone
);

  typedef enum logic {IDLE, BUSY} div_state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 1);

  div_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              lduse, sbhaz, stall;

  // Operand forwarding: Memory stage is younger, so it wins over Writeback.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (E_Rs1 != '0 && M_RegWrite && M_Rd == E_Rs1)      ForwardAE = 2'b10;
    else if (E_Rs1 != '0 && W_RegWrite && W_Rd == E_Rs1) ForwardAE = 2'b01;
    if (E_Rs2 != '0 && M_RegWrite && M_Rd == E_Rs2)      ForwardBE = 2'b10;
    else if (E_Rs2 != '0 && W_RegWrite && W_Rd == E_Rs2) ForwardBE = 2'b01;
  end

  // Hazard detection; scoreboard side uses registered state so the dependent
  // stays stalled through the DivDone cycle and reads the RF the cycle after.
  always_comb begin
    lduse = E_MemRead && (E_Rd != '0) && ((E_Rd == D_Rs1) || (E_Rd == D_Rs2));
    sbhaz = 1'b0;
    if (state_q == BUSY) begin
      if (rd_q != '0 &&
          ((rd_q == D_Rs1) || (rd_q == D_Rs2) || (D_RegWrite && rd_q == D_Rd)))
        sbhaz = 1'b1;
      if (D_IsDiv)
        sbhaz = 1'b1;
    end
    stall = lduse || sbhaz;
  end

  // Stall/flush controls; a taken branch overrides any stall.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (E_PCSrc) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // Divider scoreboard state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  // Divider next-state; a start request while BUSY is ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    DivDone = 1'b0;
    case (state_q)
      IDLE: begin
        if (E_DivStart) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
          rd_d    = E_Rd;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          DivDone = 1'b1;
          state_d = IDLE;
          rd_d    = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign DivBusy = (state_q == BUSY);
  assign DivRd   = rd_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit with DIV_LATENCY=4.
module tb_hazard_scoreboard_unit;

  logic       clk, rst;
  logic [4:0] D_Rs1, D_Rs2, D_Rd, E_Rs1, E_Rs2, E_Rd, M_Rd, W_Rd;
  logic       D_RegWrite, D_IsDiv, E_MemRead, E_DivStart, E_PCSrc, M_RegWrite, W_RegWrite;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, FlushD, FlushE, DivBusy, DivDone;
  logic [4:0] DivRd;

  int n_checks = 0;
  int n_err    = 0;

  hazard_scoreboard_unit #(.REG_AW(5), .DIV_LATENCY(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .D_Rs1(D_Rs1), .D_Rs2(D_Rs2), .D_Rd(D_Rd), .D_RegWrite(D_RegWrite), .D_IsDiv(D_IsDiv),
    .E_Rs1(E_Rs1), .E_Rs2(E_Rs2), .E_Rd(E_Rd), .E_MemRead(E_MemRead),
    .E_DivStart(E_DivStart), .E_PCSrc(E_PCSrc),
    .M_Rd(M_Rd), .W_Rd(W_Rd), .M_RegWrite(M_RegWrite), .W_RegWrite(W_RegWrite),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .DivBusy(DivBusy), .DivRd(DivRd), .DivDone(DivDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    D_Rs1 = '0; D_Rs2 = '0; D_Rd = '0; D_RegWrite = 0; D_IsDiv = 0;
    E_Rs1 = '0; E_Rs2 = '0; E_Rd = '0; E_MemRead = 0; E_DivStart = 0; E_PCSrc = 0;
    M_Rd = '0; W_Rd = '0; M_RegWrite = 0; W_RegWrite = 0;
  endtask

  task automatic check_ctl(input string tag, input logic sf, input logic fd, input logic fe);
    check({tag, ".StallF"}, StallF, sf);
    check({tag, ".StallD"}, StallD, sf);
    check({tag, ".FlushD"}, FlushD, fd);
    check({tag, ".FlushE"}, FlushE, fe);
  endtask

  // Issue a divide at cycle 0 and follow it through cycle 5. Decode inputs are
  // set by the caller; a (ignored) start request is injected in the DivDone cycle.
  task automatic run_div(input string tag, input logic [4:0] rd,
                         input logic exp_stall, input logic pcsrc);
    @(posedge clk); #2;
    E_DivStart = 1; E_Rd = rd; E_PCSrc = pcsrc;
    #1;
    check($sformatf("%s.c0.DivBusy", tag), DivBusy, 1'b0);
    check_ctl($sformatf("%s.c0", tag), 1'b0, pcsrc, pcsrc);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #2;
      E_DivStart = (k == 4);
      E_Rd = (k == 4) ? 5'd12 : 5'd0;
      #1;
      check($sformatf("%s.c%0d.DivBusy", tag, k), DivBusy, (k <= 4));
      check($sformatf("%s.c%0d.DivRd", tag, k), DivRd, (k <= 4) ? rd : 5'd0);
      check($sformatf("%s.c%0d.DivDone", tag, k), DivDone, (k == 4));
      check_ctl($sformatf("%s.c%0d", tag, k), !pcsrc && exp_stall && (k <= 4),
                pcsrc, pcsrc || (exp_stall && (k <= 4)));
    end
    E_DivStart = 0; E_Rd = '0; E_PCSrc = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    #3;
    check("rst.DivBusy", DivBusy, 1'b0);
    check("rst.DivRd", DivRd, 5'd0);
    check("rst.DivDone", DivDone, 1'b0);
    check("rst.FwdA", ForwardAE, 2'b00);
    check("rst.FwdB", ForwardBE, 2'b00);
    check_ctl("rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk); rst = 0;

    // Forwarding priority and x0 exclusion
    E_Rs1 = 5; M_Rd = 5; M_RegWrite = 1; W_Rd = 5; W_RegWrite = 1; E_Rs2 = 0;
    #1;
    check("fwd.MoverW", ForwardAE, 2'b10);
    check("fwd.x0", ForwardBE, 2'b00);
    M_RegWrite = 0; #1;
    check("fwd.Wonly", ForwardAE, 2'b01);
    E_Rs2 = 6; W_Rd = 6; M_Rd = 6; M_RegWrite = 1; #1;
    check("fwd.B.M", ForwardBE, 2'b10);
    check("fwd.A.none", ForwardAE, 2'b00);
    M_RegWrite = 0; #1;
    check("fwd.B.W", ForwardBE, 2'b01);
    E_Rs1 = 0; E_Rs2 = 0; M_Rd = 0; W_Rd = 0; M_RegWrite = 1; W_RegWrite = 1; #1;
    check("fwd.x0.A", ForwardAE, 2'b00);
    check("fwd.x0.B", ForwardBE, 2'b00);
    clear_inputs(); #1;

    // Load-use stall and branch priority
    E_MemRead = 1; E_Rd = 7; D_Rs2 = 7; #1;
    check_ctl("lduse", 1'b1, 1'b0, 1'b1);
    E_PCSrc = 1; #1;
    check_ctl("lduse.br", 1'b0, 1'b1, 1'b1);
    E_PCSrc = 0; E_Rd = 0; D_Rs2 = 0; #1;
    check_ctl("lduse.x0", 1'b0, 1'b0, 1'b0);
    E_MemRead = 0; E_Rd = 7; D_Rs2 = 7; #1;
    check_ctl("lduse.noload", 1'b0, 1'b0, 1'b0);
    clear_inputs();

    // Scoreboard: RAW, WAW, structural (second divide), unrelated with branch, x0
    D_Rs1 = 9;
    run_div("raw", 5'd9, 1'b1, 1'b0);
    clear_inputs(); D_Rd = 9; D_RegWrite = 1;
    run_div("waw", 5'd9, 1'b1, 1'b0);
    clear_inputs(); D_Rd = 9; D_RegWrite = 0;
    run_div("nowaw", 5'd9, 1'b0, 1'b0);
    clear_inputs(); D_IsDiv = 1;
    run_div("isdiv", 5'd9, 1'b1, 1'b0);
    clear_inputs(); D_Rs1 = 3;
    run_div("branch", 5'd9, 1'b0, 1'b1);
    clear_inputs();
    run_div("rdx0", 5'd0, 1'b0, 1'b0);
    clear_inputs();

    // Asynchronous reset in the middle of a divide
    @(posedge clk); #2;
    E_DivStart = 1; E_Rd = 9;
    @(posedge clk); #2;
    E_DivStart = 0; E_Rd = 0; D_Rs1 = 9;
    #1;
    check("arst.c1.DivBusy", DivBusy, 1'b1);
    @(posedge clk); #2;
    rst = 1;
    #1;
    check("arst.DivBusy", DivBusy, 1'b0);
    check("arst.DivRd", DivRd, 5'd0);
    check("arst.StallF", StallF, 1'b0);
    @(negedge clk); rst = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #3;
      check($sformatf("arst.post%0d.DivDone", k), DivDone, 1'b0);
      check($sformatf("arst.post%0d.DivBusy", k), DivBusy, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
